trace_replay_sequencer: RTL and testbench
=========================================

Name: trace_replay_sequencer

Overview:
- Owns the single port of the 256x32 trace SRAM and sequences the address trace into the cache-hierarchy simulator.
- Load phase: the host (via logic-analyzer bits) writes 32-bit trace addresses into consecutive SRAM words.
- Run phase: reads the words back in order and presents each one to the simulator with a one-cycle trace_ready strobe, then waits for the simulator's updated acknowledge (or a timeout) before issuing the next word.

Parameters:
- ADDR_W, 8, SRAM word-address width; DEPTH = 2**ADDR_W = 256.
- DATA_W, 32, SRAM word and trace-address width.
- RD_LAT, 1, cycles from the SRAM read request cycle until dout0 is valid.
- ACK_TIMEOUT, 64, maximum cycles to wait for updated after trace_ready.

Ports:
- clk  in  1  system clock (wb_clk_i at the top level)
- reset  in  1  asynchronous, active-high reset
- host_wr_valid  in  1  one-cycle pulse: append host_wr_data to the trace
- host_wr_data  in  DATA_W  trace address to store
- host_start  in  1  pulse: begin replay from word 0
- host_clear  in  1  pulse: discard trace (wr_ptr=0), return to IDLE
- sram_csb0  out  1  SRAM chip select, active low
- sram_web0  out  1  SRAM write enable, active low
- sram_addr0  out  ADDR_W  SRAM word address
- sram_din0  out  DATA_W  SRAM write data
- sram_dout0  in  DATA_W  SRAM read data
- trace_ready  out  1  one-cycle strobe: mem_addr valid for simulator
- mem_addr  out  DATA_W  trace address presented to simulator
- cache_updated  in  1  simulator acknowledge for the current address
- busy  out  1  replay in progress
- done  out  1  replay finished (sticky until start or clear)
- words_loaded  out  ADDR_W+1  trace length, 0..256
- words_issued  out  ADDR_W+1  words issued in the current or last replay
- timeout_cnt  out  8  saturating count of acknowledge timeouts
- overflow  out  1  sticky: a write was attempted at 256 words, or during replay

Behaviour:
- All outputs are registered.
- Reset state:
  - sram_csb0=1, sram_web0=1; sram_addr0, sram_din0 and mem_addr = 0.
  - trace_ready, busy, done and overflow = 0; all counters = 0; state = IDLE.
- SRAM contents are not cleared by reset or by host_clear.
- States: IDLE, RD_REQ, RD_WAIT, ISSUE, WAIT_ACK, DONE.
- Write (IDLE or DONE) with host_wr_valid and wr_ptr<256:
  - Next cycle: csb0=0, web0=0, addr0=wr_ptr[7:0], din0=data, for exactly one cycle.
  - wr_ptr increments.
- Write attempted when wr_ptr==256, or in any other state: ignored, overflow set.
- host_start in IDLE or DONE:
  - wr_ptr==0: go to DONE; done=1, words_issued=0.
  - Otherwise: rd_ptr=0, words_issued=0, done=0, busy=1, go to RD_REQ.
- host_wr_valid and host_start in the same cycle: the write is performed and start is ignored.
- RD_REQ: csb0=0, web0=1, addr0=rd_ptr for one cycle, then RD_WAIT.
- RD_WAIT: waits RD_LAT cycles, then latches sram_dout0 into mem_addr and goes to ISSUE.
- ISSUE: trace_ready=1 for exactly one cycle; words_issued increments; go to WAIT_ACK.
- WAIT_ACK:
  - Exits on cache_updated=1, or when the timer reaches ACK_TIMEOUT (timeout_cnt increments, saturating at 255).
  - On exit rd_ptr increments; rd_ptr==wr_ptr -> DONE (busy=0, done=1), else RD_REQ.
  - cache_updated arriving in the same cycle as trace_ready counts as an acknowledge.
  - cache_updated outside WAIT_ACK is ignored.
- mem_addr holds its value from the latch until the next latch.
- host_clear: honoured in any state; highest priority over start and write.
  - wr_ptr=0, busy=0, done=0, overflow=0, state=IDLE; any SRAM cycle in progress is dropped.
- Timing: minimum per-word period is 3+RD_LAT cycles (immediate acknowledge); per-word latency is RD_REQ to trace_ready = 1+RD_LAT cycles.
- Wrap-around: pointers are ADDR_W+1 bits. A full trace of 256 words replays addresses 0..255 and ends with words_issued=256.
- Asserting reset mid-replay returns to the reset state immediately; a new replay requires reloading the trace.

Decomposition:
- Package trace_seq_pkg: state enum, DEPTH, pointer-width localparam, timeout-counter width.
- Sub-module ack_timer: load/count/expire counter for ACK_TIMEOUT, reused for RD_LAT waiting.

Test Plan:
- Reset, write 0x0000_1000, 0x0000_2000, 0x0000_3000, start with a simulator model acking 2 cycles after trace_ready -> three trace_ready pulses with mem_addr 1000/2000/3000 in order; words_issued=3; done=1; busy=0; timeout_cnt=0.
- Write 256 words (value = index<<6), then one more write -> overflow=1, words_loaded=256. Replay -> last mem_addr=0x3FC0, words_issued=256.
- Simulator never acks, ACK_TIMEOUT=64, 2-word trace -> each word waits 64 cycles; timeout_cnt=2; done=1.
- host_start with empty trace -> done=1 next cycle; no SRAM read (csb0 stays 1).
- host_clear mid-replay (after word 1 of 4) -> next cycle busy=0, state IDLE, words_loaded=0, csb0=1; no further trace_ready.
- host_wr_valid and host_start asserted in the same cycle in IDLE -> one write occurs, no replay; host_wr_valid during replay -> ignored and overflow=1.

Source files
------------

// File: rtl/trace_seq_pkg.sv
// Shared types and constants for the trace replay sequencer.
// Also provides a saturating increment for its event counters.
package trace_seq_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;
  localparam int PTR_W      = ADDR_W_DEF + 1;
  localparam int TMR_W      = 8;
  localparam int TO_CNT_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_REQ   = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT_ACK = 3'd4,
    S_DONE     = 3'd5
  } seq_state_t;

  function automatic logic [TO_CNT_W-1:0] sat_inc(input logic [TO_CNT_W-1:0] v);
    logic [TO_CNT_W-1:0] r;
    if (v == {TO_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + TO_CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/trace_replay_sequencer_ack_timer.sv
// Down-counter with load/count/expire; serves both the SRAM read-latency wait
// and the acknowledge timeout.
module ack_timer
  import trace_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [TMR_W-1:0] cnt_r;

  // load has priority; counting stops at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {TMR_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != {TMR_W{1'b0}})) begin
      cnt_r <= cnt_r - TMR_W'(1);
    end
  end

  assign expired = (cnt_r == {TMR_W{1'b0}});

endmodule

// File: rtl/trace_replay_sequencer.sv
// Loads an address trace into the single-port trace SRAM, then replays it word
// by word to the cache simulator with a ready strobe and ack/timeout handshake.
module trace_replay_sequencer
  import trace_seq_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int RD_LAT      = 1,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                host_wr_valid,
  input  logic [DATA_W-1:0]   host_wr_data,
  input  logic                host_start,
  input  logic                host_clear,
  output logic                sram_csb0,
  output logic                sram_web0,
  output logic [ADDR_W-1:0]   sram_addr0,
  output logic [DATA_W-1:0]   sram_din0,
  input  logic [DATA_W-1:0]   sram_dout0,
  output logic                trace_ready,
  output logic [DATA_W-1:0]   mem_addr,
  input  logic                cache_updated,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     words_loaded,
  output logic [ADDR_W:0]     words_issued,
  output logic [TO_CNT_W-1:0] timeout_cnt,
  output logic                overflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] FULL_PTR = PW'(2 ** ADDR_W);

  seq_state_t       state_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    issued_r;
  logic [PW-1:0]    rd_ptr_inc_s;
  logic             ack_seen_r;
  logic             ack_s;
  logic             wr_ok_s;
  logic             tmr_load_s;
  logic             tmr_en_s;
  logic             tmr_expired_s;
  logic [TMR_W-1:0] tmr_val_s;

  // The timer is armed during RD_REQ for the read latency and during ISSUE for the ack window
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_en_s   = 1'b0;
    tmr_val_s  = TMR_W'(ACK_TIMEOUT - 1);
    case (state_r)
      S_RD_REQ: begin
        tmr_load_s = 1'b1;
        tmr_val_s  = TMR_W'(RD_LAT - 1);
      end
      S_ISSUE: begin
        tmr_load_s = 1'b1;
      end
      S_RD_WAIT, S_WAIT_ACK: begin
        tmr_en_s = 1'b1;
      end
      default: begin
        tmr_load_s = 1'b0;
      end
    endcase
  end

  ack_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .en       (tmr_en_s),
    .expired  (tmr_expired_s)
  );

  assign rd_ptr_inc_s = rd_ptr_r + PW'(1);
  assign wr_ok_s      = ((state_r == S_IDLE) || (state_r == S_DONE)) && (wr_ptr_r != FULL_PTR);
  assign ack_s        = ack_seen_r || cache_updated;
  assign words_loaded = wr_ptr_r;
  assign words_issued = issued_r;

  // Main sequencer FSM; SRAM strobes and trace_ready default to idle every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      issued_r    <= {PW{1'b0}};
      ack_seen_r  <= 1'b0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_addr0  <= {ADDR_W{1'b0}};
      sram_din0   <= {DATA_W{1'b0}};
      mem_addr    <= {DATA_W{1'b0}};
      trace_ready <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_cnt <= {TO_CNT_W{1'b0}};
      overflow    <= 1'b0;
    end else begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      trace_ready <= 1'b0;
      if (host_clear) begin
        state_r  <= S_IDLE;
        wr_ptr_r <= {PW{1'b0}};
        busy     <= 1'b0;
        done     <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (host_wr_valid && !wr_ok_s) begin
          overflow <= 1'b1;
        end
        case (state_r)
          S_IDLE, S_DONE: begin
            if (host_wr_valid) begin
              if (wr_ok_s) begin
                sram_csb0  <= 1'b0;
                sram_web0  <= 1'b0;
                sram_addr0 <= wr_ptr_r[ADDR_W-1:0];
                sram_din0  <= host_wr_data;
                wr_ptr_r   <= wr_ptr_r + PW'(1);
              end
            end else if (host_start) begin
              issued_r <= {PW{1'b0}};
              if (wr_ptr_r == {PW{1'b0}}) begin
                state_r <= S_DONE;
                done    <= 1'b1;
              end else begin
                rd_ptr_r   <= {PW{1'b0}};
                done       <= 1'b0;
                busy       <= 1'b1;
                state_r    <= S_RD_REQ;
                sram_csb0  <= 1'b0;
                sram_addr0 <= {ADDR_W{1'b0}};
              end
            end
          end
          S_RD_REQ: begin
            state_r <= S_RD_WAIT;
          end
          S_RD_WAIT: begin
            if (tmr_expired_s) begin
              mem_addr    <= sram_dout0;
              trace_ready <= 1'b1;
              issued_r    <= issued_r + PW'(1);
              state_r     <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            // an ack coinciding with the strobe must not be lost
            ack_seen_r <= cache_updated;
            state_r    <= S_WAIT_ACK;
          end
          S_WAIT_ACK: begin
            if (ack_s || tmr_expired_s) begin
              ack_seen_r <= 1'b0;
              if (!ack_s) begin
                timeout_cnt <= sat_inc(timeout_cnt);
              end
              rd_ptr_r <= rd_ptr_inc_s;
              if (rd_ptr_inc_s == wr_ptr_r) begin
                state_r <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                state_r    <= S_RD_REQ;
                sram_csb0  <= 1'b0;
                sram_addr0 <= rd_ptr_inc_s[ADDR_W-1:0];
              end
            end
          end
          default: begin
            state_r <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trace_replay_sequencer.sv
// Scoreboard bench: stimulus pushes expected trace addresses, a monitor pops
// them on every trace_ready strobe; a behavioural SRAM and ack model close the loop.
module tb_trace_replay_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_wr_valid;
  logic [31:0] host_wr_data;
  logic        host_start;
  logic        host_clear;
  logic        sram_csb0;
  logic        sram_web0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;
  logic        trace_ready;
  logic [31:0] mem_addr;
  logic        cache_updated;
  logic        busy;
  logic        done;
  logic [8:0]  words_loaded;
  logic [8:0]  words_issued;
  logic [7:0]  timeout_cnt;
  logic        overflow;

  logic [31:0] mem [256];
  logic [31:0] exp_q [$];
  logic [31:0] last_addr;
  logic [31:0] mon_exp;
  logic        ack_en;
  int          errors = 0;
  int          checks = 0;
  int          strobes = 0;

  trace_replay_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .host_wr_valid (host_wr_valid),
    .host_wr_data  (host_wr_data),
    .host_start    (host_start),
    .host_clear    (host_clear),
    .sram_csb0     (sram_csb0),
    .sram_web0     (sram_web0),
    .sram_addr0    (sram_addr0),
    .sram_din0     (sram_din0),
    .sram_dout0    (sram_dout0),
    .trace_ready   (trace_ready),
    .mem_addr      (mem_addr),
    .cache_updated (cache_updated),
    .busy          (busy),
    .done          (done),
    .words_loaded  (words_loaded),
    .words_issued  (words_issued),
    .timeout_cnt   (timeout_cnt),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // single-port SRAM with one cycle read latency
  always @(posedge clk) begin
    if (sram_csb0 == 1'b0) begin
      if (sram_web0 == 1'b0) begin
        mem[sram_addr0] <= sram_din0;
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // simulator model: acknowledge two cycles after each strobe
  initial begin
    cache_updated = 1'b0;
    forever begin
      @(negedge clk);
      if (trace_ready === 1'b1 && ack_en) begin
        repeat (2) @(negedge clk);
        cache_updated = 1'b1;
        @(negedge clk);
        cache_updated = 1'b0;
      end
    end
  end

  // monitor: every strobe must match the oldest expected address
  initial begin
    forever begin
      @(negedge clk);
      if (trace_ready === 1'b1) begin
        strobes++;
        last_addr = mem_addr;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got mem_addr=%0h, required no strobe", mem_addr);
        end else begin
          mon_exp = exp_q.pop_front();
          check("mem_addr", mem_addr, mon_exp);
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] d);
    host_wr_valid = 1'b1;
    host_wr_data  = d;
    @(negedge clk);
    host_wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    host_start = 1'b1;
    @(negedge clk);
    host_start = 1'b0;
  endtask

  task automatic pulse_clear();
    host_clear = 1'b1;
    @(negedge clk);
    host_clear = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    host_wr_valid = 1'b0;
    host_wr_data  = 32'd0;
    host_start    = 1'b0;
    host_clear    = 1'b0;
    ack_en        = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_csb0", {31'd0, sram_csb0}, 32'd1);
    check("rst_web0", {31'd0, sram_web0}, 32'd1);
    check("rst_addr0", {24'd0, sram_addr0}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_flags", {28'd0, trace_ready, busy, done, overflow}, 32'd0);
    check("rst_counts", {6'd0, words_loaded, words_issued, timeout_cnt}, 32'd0);

    // three-word trace with prompt acks
    do_write(32'h0000_1000);
    check("wr_strobe", {30'd0, sram_csb0, sram_web0}, 32'd0);
    check("wr_addr0", {24'd0, sram_addr0}, 32'd0);
    check("wr_din0", sram_din0, 32'h0000_1000);
    do_write(32'h0000_2000);
    check("wr_addr1", {24'd0, sram_addr0}, 32'd1);
    do_write(32'h0000_3000);
    @(negedge clk);
    check("wr_single_cycle", {31'd0, sram_csb0}, 32'd1);
    check("loaded3", {23'd0, words_loaded}, 32'd3);
    exp_q.push_back(32'h0000_1000);
    exp_q.push_back(32'h0000_2000);
    exp_q.push_back(32'h0000_3000);
    pulse_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_rd_req", {30'd0, sram_csb0, sram_web0}, 32'd1);
    wait_done(100, n);
    check("t1_issued", {23'd0, words_issued}, 32'd3);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_timeouts", {24'd0, timeout_cnt}, 32'd0);
    check("t1_queue_empty", exp_q.size(), 32'd0);

    // full 256-word trace plus one overflowing write
    pulse_clear();
    check("clear_loaded", {23'd0, words_loaded}, 32'd0);
    check("clear_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      do_write(i << 6);
    end
    do_write(32'hDEAD_BEEF);
    check("full_overflow", {31'd0, overflow}, 32'd1);
    check("full_loaded", {23'd0, words_loaded}, 32'd256);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(i << 6);
    end
    pulse_start();
    wait_done(2000, n);
    check("full_issued", {23'd0, words_issued}, 32'd256);
    check("full_last_addr", last_addr, 32'h0000_3FC0);
    check("full_queue_empty", exp_q.size(), 32'd0);

    // no acknowledges: both words time out after 64 cycles each
    pulse_clear();
    check("clear_overflow", {31'd0, overflow}, 32'd0);
    do_write(32'hA5A5_0001);
    do_write(32'hA5A5_0002);
    exp_q.push_back(32'hA5A5_0001);
    exp_q.push_back(32'hA5A5_0002);
    ack_en = 1'b0;
    pulse_start();
    wait_done(300, n);
    check("noack_duration_ok", {31'd0, (n >= 128 && n <= 140)}, 32'd1);
    check("noack_timeouts", {24'd0, timeout_cnt}, 32'd2);
    check("noack_queue_empty", exp_q.size(), 32'd0);
    ack_en = 1'b1;

    // start with an empty trace
    pulse_clear();
    pulse_start();
    check("empty_done", {31'd0, done}, 32'd1);
    check("empty_csb0", {31'd0, sram_csb0}, 32'd1);
    check("empty_issued", {23'd0, words_issued}, 32'd0);
    @(negedge clk);
    check("empty_csb0_later", {31'd0, sram_csb0}, 32'd1);
    check("empty_busy", {31'd0, busy}, 32'd0);

    // clear while replaying a four-word trace
    pulse_clear();
    for (int i = 0; i < 4; i++) begin
      do_write(32'hC000_0000 + i);
      exp_q.push_back(32'hC000_0000 + i);
    end
    pulse_start();
    n = 0;
    while (words_issued !== 9'd1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_first_word", {23'd0, words_issued}, 32'd1);
    pulse_clear();
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_loaded", {23'd0, words_loaded}, 32'd0);
    check("mid_csb0", {31'd0, sram_csb0}, 32'd1);
    exp_q.delete();
    n = strobes;
    repeat (20) @(negedge clk);
    check("mid_no_more_strobes", strobes, n);

    // write and start together: write only
    pulse_clear();
    host_wr_valid = 1'b1;
    host_wr_data  = 32'hE000_0000;
    host_start    = 1'b1;
    @(negedge clk);
    host_wr_valid = 1'b0;
    host_start    = 1'b0;
    check("ws_write", {30'd0, sram_csb0, sram_web0}, 32'd0);
    check("ws_loaded", {23'd0, words_loaded}, 32'd1);
    @(negedge clk);
    check("ws_no_replay", {30'd0, busy, sram_csb0}, 32'd1);

    // write during replay is dropped and flagged
    do_write(32'hE000_0001);
    exp_q.push_back(32'hE000_0000);
    exp_q.push_back(32'hE000_0001);
    check("pre_overflow", {31'd0, overflow}, 32'd0);
    pulse_start();
    do_write(32'hBAD0_BAD0);
    check("replay_wr_overflow", {31'd0, overflow}, 32'd1);
    check("replay_wr_loaded", {23'd0, words_loaded}, 32'd2);
    wait_done(100, n);
    check("replay_wr_issued", {23'd0, words_issued}, 32'd2);
    check("replay_wr_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
